scroll_text_buffer: RTL and testbench
=====================================

// Module: scroll_text_buffer
// PURPOSE
// - Upstream feeder for the 4-digit 7-seg scanning mux: holds a message of up to DEPTH segment codes and presents a
//   DIGITS-wide window that advances one character every STEP_CYCLES clocks, wrapping circularly.
// - Replaces hard-coded per-state digit tables; message written by control logic, window drives digit regs of the mux.
// PARAMETERS
// - DEPTH        16          message storage, characters (power of 2)
// - SEG_W        8           segment code width, {a,b,c,d,e,f,g,dp}, MSB=a; blank = 8'h00
// - DIGITS       4           window width, characters
// - STEP_CYCLES  50_000_000  clocks per scroll step (0.5 s @100 MHz); bench overrides to 4
// PORTS
// - fastclk    in   1               100 MHz system clock; single clock domain
// - resetin    in   1               synchronous, active-low reset
// - wr_en      in   1               write strobe, accepted only when wr_ready=1
// - wr_addr    in   $clog2(DEPTH)   character index
// - wr_data    in   SEG_W           segment code
// - wr_ready   out  1               1 in IDLE only
// - msg_len    in   $clog2(DEPTH)+1 message length, sampled on start
// - start      in   1               1-cycle pulse: begin scrolling
// - stop       in   1               1-cycle pulse: halt, blank window
// - busy       out  1               1 in SCROLL
// - window     out  DIGITS*SEG_W    [MSB slice]=leftmost digit (select 4'b1000) ... [LSB slice]=rightmost
// - pos        out  $clog2(DEPTH)   index of leftmost character
// - wrap       out  1               1-cycle pulse when pos goes len-1 -> 0
// BEHAVIOUR
// - Reset (resetin=0 at edge): state IDLE, mem[*]=8'h00, window=0, pos=0, len=DIGITS, busy=0, wrap=0, wr_ready=1,
//   step counter=0. Reset mid-scroll aborts immediately, same values.
// - States: IDLE -> SCROLL on start (and not stop); SCROLL -> IDLE on stop. No other states.
// - IDLE: wr_en writes mem[wr_addr]<=wr_data at the edge; window held at 0; pos held 0.
// - SCROLL: wr_en ignored (no write, no error). start while in SCROLL ignored.
// - start sampled at edge N: len <= clamp(msg_len, DIGITS, DEPTH); pos=0, counter=0, busy=1 after edge N;
//   window = mem[0..DIGITS-1] after edge N+1 (window is registered: always 1 clock behind pos).
// - Step: counter counts 0..STEP_CYCLES-1; on edge where counter==STEP_CYCLES-1: counter<=0,
//   pos<=(pos==len-1)?0:pos+1, wrap<=1 for that wrap only (1 cycle), else wrap<=0.
// - Window digit k (k=0 leftmost) = mem[idx_k], idx_k = pos+k, minus len if >= len (single subtract valid since
//   len>=DIGITS>k and pos<len). Width of sum: $clog2(DEPTH)+1 bits, no overflow.
// - stop at edge M (any state): state IDLE, busy=0, window=0, pos=0, wrap=0, counter=0 after edge M.
//   start and stop same cycle: stop wins.
// - msg_len=0..DIGITS-1 -> len=DIGITS; msg_len>DEPTH -> len=DEPTH. Unwritten cells show blank.
// - All outputs registered; no combinational path from inputs to outputs.
// STRUCTURE
// - Shared package disp_pkg: SEG_BLANK=8'h00, SEG_DIGIT[0:9] codes (e.g. '0'=8'hFC, '1'=8'h60, '2'=8'hDA,
//   '5'=8'hB6, '9'=8'hF6), state encoding ST_IDLE/ST_SCROLL, SEG_W.
// - One sub-module: step_prescaler (param STEP_CYCLES; in: fastclk, resetin, clr, en; out: step pulse).
//   Storage, FSM, index arithmetic and window regs stay in this module.
// TESTING (STEP_CYCLES=4)
// - Reset: hold resetin=0 2 clocks -> window=0, pos=0, busy=0, wr_ready=1, wrap=0.
// - Write mem[0..5]={DA,FC,60,F6,00,FC}, msg_len=6, start -> 2 clocks later window=32'hDAFC60F6; after 4 more
//   clocks pos=1, next clock window=32'hFC60F600.
// - Same message, run 24 clocks -> wrap pulses exactly once per 6 steps, on pos 5->0; window at pos=4 = 32'h00FCDAFC.
// - msg_len=2 -> len clamped to 4; msg_len=20 -> len=16; check pos wrap points 3->0 and 15->0.
// - wr_en during SCROLL to addr 0 with 8'hFF -> mem unchanged after stop/start; start+stop same cycle -> stays IDLE.
// - resetin=0 mid-scroll at pos=3 -> next clock all reset values; mem cleared (window blank after restart).

Source files
------------

// File: rtl/disp_pkg.sv
// Shared display definitions: blank/digit segment codes and scroller state encoding.
package disp_pkg;

    localparam int unsigned SEG_W = 8;

    // Segment order {a,b,c,d,e,f,g,dp}, a in the MSB.
    localparam logic [SEG_W-1:0] SEG_BLANK = 8'h00;

    localparam logic [SEG_W-1:0] SEG_DIGIT [10] = '{
        8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66,
        8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6
    };

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SCROLL = 1'b1
    } state_e;

endpackage

// File: rtl/scroll_text_buffer_if.sv
// Control/data bus between message writer / display mux and the scroll buffer.
interface scroll_text_buffer_if #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned SEG_W  = 8,
    parameter int unsigned DIGITS = 4
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic                    wr_en;
    logic [AW-1:0]           wr_addr;
    logic [SEG_W-1:0]        wr_data;
    logic                    wr_ready;
    logic [LW-1:0]           msg_len;
    logic                    start;
    logic                    stop;
    logic                    busy;
    logic [DIGITS*SEG_W-1:0] window;
    logic [AW-1:0]           pos;
    logic                    wrap;

    modport master (
        output wr_en, wr_addr, wr_data, msg_len, start, stop,
        input  wr_ready, busy, window, pos, wrap
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, msg_len, start, stop,
        output wr_ready, busy, window, pos, wrap
    );

endinterface

// File: rtl/scroll_text_buffer_step_prescaler.sv
// Step prescaler: one-cycle step pulse every STEP_CYCLES enabled clocks.
module step_prescaler #(
    parameter int unsigned STEP_CYCLES = 50_000_000
) (
    input  logic fastclk,
    input  logic resetin,
    input  logic clr,
    input  logic en,
    output logic step_c
);
    localparam int unsigned CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Terminal count detection and next count value.
    always_comb begin
        step_c = en && !clr && (cnt_q == CNT_W'(STEP_CYCLES - 1));
        cnt_d  = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (step_c) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge fastclk) begin
        if (!resetin) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/scroll_text_buffer.sv
// Circular message store presenting a DIGITS-wide window that scrolls one character per step.
module scroll_text_buffer
    import disp_pkg::*;
#(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned SEG_W       = disp_pkg::SEG_W,
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned STEP_CYCLES = 50_000_000
) (
    input  logic                 fastclk,
    input  logic                 resetin,
    scroll_text_buffer_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned WW = DIGITS * SEG_W;

    state_e            state_q, state_d;
    logic [SEG_W-1:0]  mem_q [DEPTH];
    logic [SEG_W-1:0]  mem_d [DEPTH];
    logic [LW-1:0]     len_q, len_d;
    logic [AW-1:0]     pos_q, pos_d;
    logic [WW-1:0]     window_q, window_d;
    logic              wrap_q, wrap_d;
    logic              busy_q, busy_d;
    logic              wr_ready_q, wr_ready_d;

    logic              start_acc_c;
    logic              clr_c;
    logic              step_c;

    assign start_acc_c = bus.start && !bus.stop && (state_q == ST_IDLE);
    assign clr_c       = bus.stop || start_acc_c;

    step_prescaler #(
        .STEP_CYCLES (STEP_CYCLES)
    ) u_step (
        .fastclk (fastclk),
        .resetin (resetin),
        .clr     (clr_c),
        .en      (state_q == ST_SCROLL),
        .step_c  (step_c)
    );

    // Next state, length capture, position advance and wrap pulse.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        pos_d   = pos_q;
        wrap_d  = 1'b0;
        if (bus.stop) begin
            state_d = ST_IDLE;
            pos_d   = '0;
        end else if (start_acc_c) begin
            state_d = ST_SCROLL;
            pos_d   = '0;
            if (bus.msg_len < LW'(DIGITS)) begin
                len_d = LW'(DIGITS);
            end else if (bus.msg_len > LW'(DEPTH)) begin
                len_d = LW'(DEPTH);
            end else begin
                len_d = bus.msg_len;
            end
        end else if ((state_q == ST_SCROLL) && step_c) begin
            if (LW'(pos_q) == len_q - LW'(1)) begin
                pos_d  = '0;
                wrap_d = 1'b1;
            end else begin
                pos_d = pos_q + AW'(1);
            end
        end
        busy_d     = (state_d == ST_SCROLL);
        wr_ready_d = (state_d == ST_IDLE);
    end

    // Message writes are accepted only while idle.
    always_comb begin
        mem_d = mem_q;
        if ((state_q == ST_IDLE) && bus.wr_en) begin
            mem_d[bus.wr_addr] = bus.wr_data;
        end
    end

    // Window lags pos by one clock; index wraps with a single subtract of len.
    always_comb begin
        logic [LW-1:0] idx;
        window_d = '0;
        idx      = '0;
        if ((state_q == ST_SCROLL) && !bus.stop) begin
            for (int unsigned k = 0; k < DIGITS; k++) begin
                idx = LW'(pos_q) + LW'(k);
                if (idx >= len_q) begin
                    idx = idx - len_q;
                end
                window_d[(DIGITS-1-k)*SEG_W +: SEG_W] = mem_q[idx[AW-1:0]];
            end
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge fastclk) begin
        if (!resetin) begin
            state_q    <= ST_IDLE;
            len_q      <= LW'(DIGITS);
            pos_q      <= '0;
            window_q   <= '0;
            wrap_q     <= 1'b0;
            busy_q     <= 1'b0;
            wr_ready_q <= 1'b1;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= SEG_W'(SEG_BLANK);
            end
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            pos_q      <= pos_d;
            window_q   <= window_d;
            wrap_q     <= wrap_d;
            busy_q     <= busy_d;
            wr_ready_q <= wr_ready_d;
            mem_q      <= mem_d;
        end
    end

    assign bus.window   = window_q;
    assign bus.pos      = pos_q;
    assign bus.wrap     = wrap_q;
    assign bus.busy     = busy_q;
    assign bus.wr_ready = wr_ready_q;

endmodule

// File: tb/tb_scroll_text_buffer.sv
// Bench for scroll_text_buffer: per-cycle comparison against a behavioural model plus literal checkpoints.
module tb_scroll_text_buffer;
    import disp_pkg::*;

    localparam int STEP = 4;
    localparam int DEP  = 16;
    localparam int DIG  = 4;

    logic fastclk = 1'b0;
    logic resetin;
    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 1'b0;

    scroll_text_buffer_if #(.DEPTH(16), .SEG_W(8), .DIGITS(4)) bus ();

    scroll_text_buffer #(
        .DEPTH(16), .SEG_W(8), .DIGITS(4), .STEP_CYCLES(STEP)
    ) dut (
        .fastclk (fastclk),
        .resetin (resetin),
        .bus     (bus)
    );

    always #5 fastclk = ~fastclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h expected=%08h t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: position = (elapsed clocks / STEP) mod len, window shows previous position.
    logic [7:0]  m_mem [DEP];
    bit          m_run;
    int          m_len, m_pos, m_ticks;
    logic [31:0] m_win;
    bit          m_wrap;

    function automatic logic [31:0] win_of(input int p);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < DIG; k++) r[(DIG-1-k)*8 +: 8] = m_mem[(p + k) % m_len];
        return r;
    endfunction

    function automatic int clamp_len(input int l);
        if (l < DIG) return DIG;
        if (l > DEP) return DEP;
        return l;
    endfunction

    always @(posedge fastclk) begin
        if (!resetin) begin
            for (int i = 0; i < DEP; i++) m_mem[i] = 8'h00;
            m_run = 0; m_len = DIG; m_pos = 0; m_win = '0; m_wrap = 0; m_ticks = 0;
        end else begin
            if (!m_run && bus.wr_en) m_mem[bus.wr_addr] = bus.wr_data;
            m_wrap = 0;
            if (bus.stop) begin
                m_run = 0; m_pos = 0; m_win = '0;
            end else if (!m_run) begin
                if (bus.start) begin
                    m_run = 1; m_len = clamp_len(int'(bus.msg_len)); m_ticks = 0; m_pos = 0;
                end
                m_win = '0;
            end else begin
                m_win = win_of(m_pos);
                m_ticks++;
                if (m_ticks % STEP == 0) begin
                    m_pos  = (m_ticks / STEP) % m_len;
                    m_wrap = (m_pos == 0);
                end
            end
        end
    end

    // Compare every cycle once the model has seen a reset.
    always @(negedge fastclk) begin
        if (chk_en) begin
            check("window", bus.window, m_win);
            check("pos", 32'(bus.pos), 32'(m_pos));
            check("busy", 32'(bus.busy), 32'(m_run));
            check("wr_ready", 32'(bus.wr_ready), 32'(!m_run));
            check("wrap", 32'(bus.wrap), 32'(m_wrap));
        end
    end

    task automatic clk(input int n);
        repeat (n) @(negedge fastclk);
    endtask

    task automatic pulse_start(input int len);
        bus.msg_len = 5'(len);
        bus.start   = 1'b1;
        clk(1);
        bus.start   = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.stop = 1'b1;
        clk(1);
        bus.stop = 1'b0;
    endtask

    // Run n clocks, return the highest pos seen and the wrap count; each wrap must follow pos=last.
    task automatic run_observe(input int n, input int last, output int maxp, output int wraps);
        int prev;
        maxp  = 0;
        wraps = 0;
        prev  = int'(bus.pos);
        for (int i = 0; i < n; i++) begin
            clk(1);
            if (int'(bus.pos) > maxp) maxp = int'(bus.pos);
            if (bus.wrap) begin
                wraps++;
                check("wrap_from_last", 32'(prev), 32'(last));
            end
            prev = int'(bus.pos);
        end
    endtask

    initial begin
        logic [7:0] msg [6];
        int maxp, wraps, prev;
        bit seen4, found;

        msg = '{SEG_DIGIT[2], SEG_DIGIT[0], SEG_DIGIT[1], SEG_DIGIT[9], SEG_BLANK, SEG_DIGIT[0]};
        bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.msg_len = '0; bus.start = 0; bus.stop = 0;
        resetin = 1'b0;

        // Reset values
        clk(2);
        chk_en = 1'b1;
        check("rst_window", bus.window, 32'h0);
        check("rst_pos", 32'(bus.pos), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_wr_ready", 32'(bus.wr_ready), 32'd1);
        check("rst_wrap", 32'(bus.wrap), 32'd0);
        resetin = 1'b1;

        // Load message and start
        for (int i = 0; i < 6; i++) begin
            bus.wr_en = 1; bus.wr_addr = 4'(i); bus.wr_data = msg[i];
            clk(1);
        end
        bus.wr_en = 0;
        pulse_start(6);
        check("start_busy", 32'(bus.busy), 32'd1);
        clk(1);
        check("first_window", bus.window, 32'hDAFC60F6);
        clk(2);
        check("pos0_held", 32'(bus.pos), 32'd0);
        clk(1);
        check("pos_step1", 32'(bus.pos), 32'd1);
        clk(1);
        check("window_step1", bus.window, 32'hFC60F600);

        // 24 clocks: one wrap, window at pos 4
        wraps = 0; seen4 = 0; prev = int'(bus.pos);
        for (int i = 0; i < 24; i++) begin
            clk(1);
            if (bus.wrap) begin
                wraps++;
                check("wrap6_from5", 32'(prev), 32'd5);
            end
            if (!seen4 && prev == 4 && bus.pos == 4'd4) begin
                seen4 = 1;
                check("window_pos4", bus.window, 32'h00FCDAFC);
            end
            prev = int'(bus.pos);
        end
        check("wrap_count_24", 32'(wraps), 32'd1);
        check("pos4_seen", 32'(seen4), 32'd1);

        pulse_stop();
        check("stop_busy", 32'(bus.busy), 32'd0);
        check("stop_window", bus.window, 32'h0);

        // Length clamped low
        pulse_start(2);
        run_observe(40, 3, maxp, wraps);
        check("len2_maxpos", 32'(maxp), 32'd3);
        check("len2_wraps", 32'(wraps), 32'd2);
        pulse_stop();

        // Length clamped high
        pulse_start(20);
        run_observe(70, 15, maxp, wraps);
        check("len20_maxpos", 32'(maxp), 32'd15);
        check("len20_wraps", 32'(wraps), 32'd1);
        pulse_stop();

        // Writes while scrolling are dropped
        pulse_start(6);
        clk(2);
        bus.wr_en = 1; bus.wr_addr = 4'd0; bus.wr_data = 8'hFF;
        clk(2);
        bus.wr_en = 0;
        pulse_stop();
        pulse_start(6);
        clk(1);
        check("scroll_write_ignored", bus.window, 32'hDAFC60F6);
        pulse_stop();

        // Simultaneous start and stop stays idle
        bus.msg_len = 5'd6; bus.start = 1; bus.stop = 1;
        clk(1);
        bus.start = 0; bus.stop = 0;
        check("startstop_busy", 32'(bus.busy), 32'd0);
        check("startstop_ready", 32'(bus.wr_ready), 32'd1);
        clk(2);
        check("startstop_busy_later", 32'(bus.busy), 32'd0);

        // Reset mid-scroll at pos 3
        pulse_start(6);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            clk(1);
            if (bus.pos == 4'd3) found = 1;
        end
        check("reach_pos3", 32'(found), 32'd1);
        resetin = 1'b0;
        clk(1);
        check("mid_rst_window", bus.window, 32'h0);
        check("mid_rst_pos", 32'(bus.pos), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_ready", 32'(bus.wr_ready), 32'd1);
        check("mid_rst_wrap", 32'(bus.wrap), 32'd0);
        resetin = 1'b1;
        pulse_start(6);
        clk(1);
        check("mem_cleared", bus.window, 32'h0);
        clk(2);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
